// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller driving an external serializer
module uart_tx_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int WDOG_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  tx_out,
    output logic                  wdog_err
);

    localparam int WDOG_LIMIT = DATA_WIDTH + WDOG_MARGIN;
    localparam int CNT_W      = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wdog_cnt;
    logic             par_bit;
    logic             par_en_q;
    logic             accept;
    logic             wdog_last;
    logic             wdog_hit;

    assign accept    = (state == S_IDLE) && data_valid;
    // wdog_cnt holds (DATA cycle index - 1), so this is the final permitted DATA cycle
    assign wdog_last = (wdog_cnt == CNT_W'(WDOG_LIMIT - 1));
    assign wdog_hit  = (state == S_DATA) && !ser_done && wdog_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (data_valid) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_DATA;
            end
            S_DATA: begin
                // ser_done takes priority over a coincident watchdog limit
                if (ser_done) begin
                    state_nxt = par_en_q ? S_PARITY : S_STOP;
                end else if (wdog_last) begin
                    state_nxt = S_STOP;
                end
            end
            S_PARITY: begin
                state_nxt = S_STOP;
            end
            S_STOP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state != S_DATA) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
        end
    end

    // par_typ is folded into par_bit at accept, so later host changes cannot leak in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else if (accept) begin
            par_bit  <= (^data_in) ^ par_typ;
            par_en_q <= par_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= wdog_hit;
        end
    end

    always_comb begin
        ser_en = 1'b0;
        busy   = 1'b0;
        tx_out = 1'b1;
        case (state)
            S_IDLE: begin
                ser_en = 1'b0;
                busy   = 1'b0;
                tx_out = 1'b1;
            end
            S_START: begin
                ser_en = 1'b1;
                busy   = 1'b1;
                tx_out = 1'b0;
            end
            S_DATA: begin
                ser_en = 1'b1;
                busy   = 1'b1;
                tx_out = ser_data;
            end
            S_PARITY: begin
                ser_en = 1'b0;
                busy   = 1'b1;
                tx_out = par_bit;
            end
            S_STOP: begin
                ser_en = 1'b0;
                busy   = 1'b1;
                tx_out = 1'b1;
            end
            default: begin
                ser_en = 1'b0;
                busy   = 1'b0;
                tx_out = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl with serializer model
module tb_uart_tx_ctrl;

    localparam int DW  = 8;
    localparam int LIM = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          ser_data;
    logic          ser_done;
    logic          ser_en;
    logic          busy;
    logic          tx_out;
    logic          wdog_err;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .WDOG_MARGIN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .busy       (busy),
        .tx_out     (tx_out),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    // serializer model: 0 = done on bit 8, 1 = done on 10th DATA cycle, 2 = never done
    int            ser_mode = 0;
    logic [DW-1:0] ser_sr;
    int            ser_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_cnt <= 0;
            ser_sr  <= '0;
        end else if (!busy) begin
            ser_sr  <= data_in;
            ser_cnt <= 0;
        end else if (ser_en) begin
            ser_cnt <= ser_cnt + 1;
        end
    end

    always_comb begin
        ser_data = 1'b1;
        ser_done = 1'b0;
        if (ser_cnt >= 1) ser_data = ser_sr[3'((ser_cnt - 1) % 8)];
        ser_done = (ser_mode == 0 && ser_cnt == 8) || (ser_mode == 1 && ser_cnt == LIM);
    end

    typedef struct {
        int          len;
        logic [15:0] bits;
        int          wdog_idx;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   frames_sent = 0;
    int   frames_done = 0;
    bit   abort_flag = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: start bit, serializer bits LSB first, parity from a ones count, stop bit
    function automatic exp_t model(input logic [7:0] d, input bit pe, input bit pt,
                                   input int mode, input int gap);
        exp_t e;
        int   n;
        int   ones;
        int   ndata;
        e.bits = '0;
        n = 0;
        e.bits[n] = 1'b0;
        n++;
        ndata = (mode == 0) ? 8 : LIM;
        for (int i = 0; i < ndata; i++) begin
            e.bits[n] = d[i % 8];
            n++;
        end
        if (pe && mode != 2) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            e.bits[n] = 1'((ones % 2) ^ int'(pt));
            n++;
        end
        e.bits[n] = 1'b1;
        n++;
        e.len      = n;
        e.wdog_idx = (mode == 2) ? n - 1 : -1;
        e.gap      = gap;
        return e;
    endfunction

    // monitor: captures each busy-high window and checks it against the queued expectation
    bit          in_frame = 0;
    int          cap_len;
    logic [15:0] cap_bits;
    int          cap_w;
    int          cap_nw;
    int          cap_gap;
    int          idle_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (!in_frame) begin
                    in_frame = 1;
                    cap_len  = 0;
                    cap_bits = '0;
                    cap_w    = -1;
                    cap_nw   = 0;
                    cap_gap  = idle_cnt;
                end
                if (cap_len < 16) cap_bits[cap_len[3:0]] = tx_out;
                if (wdog_err) begin
                    cap_w = cap_len;
                    cap_nw++;
                end
                cap_len++;
                idle_cnt = 0;
            end else begin
                if (in_frame) begin
                    in_frame = 0;
                    if (abort_flag) begin
                        abort_flag = 0;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end else if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'(cap_len), 32'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("frame_len", 32'(cap_len), 32'(e.len));
                        chk("frame_bits", 32'(cap_bits), 32'(e.bits));
                        chk("wdog_pos", 32'(cap_w), 32'(e.wdog_idx));
                        chk("wdog_pulses", 32'(cap_nw), (e.wdog_idx >= 0) ? 32'(1) : 32'(0));
                        if (e.gap >= 0) chk("idle_gap", 32'(cap_gap), 32'(e.gap));
                        chk("idle_line", {29'b0, tx_out, ser_en, wdog_err}, 32'b100);
                        frames_done++;
                    end
                end
                idle_cnt++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic send(input logic [7:0] d, input bit pe, input bit pt,
                        input int mode, input bit wiggle);
        int n = 0;
        wait_idle();
        ser_mode   = mode;
        data_in    = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        exp_q.push_back(model(d, pe, pt, mode, -1));
        frames_sent++;
        @(negedge clk);
        data_valid = 1'b0;
        chk("accept_busy", 32'(busy), 32'(1));
        while (busy && n < 100) begin
            if (wiggle) begin
                data_valid = 1'($urandom_range(0, 1));
                data_in    = 8'($urandom);
                par_en     = 1'($urandom_range(0, 1));
                par_typ    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        data_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_tx", 32'(tx_out), 32'(1));
        chk("rst_ser_en", 32'(ser_en), 32'(0));
        chk("rst_wdog", 32'(wdog_err), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hA5, 0, 0, 0, 0);
        send(8'hA5, 1, 0, 0, 0);
        send(8'hA5, 1, 1, 0, 0);
        send(8'h07, 1, 0, 0, 0);
        send(8'h00, 1, 1, 0, 0);

        // data_valid held high across four back-to-back bytes
        wait_idle();
        data_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            bit         pe;
            bit         pt;
            int         n;
            b  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            ser_mode = 0;
            data_in  = b;
            par_en   = pe;
            par_typ  = pt;
            exp_q.push_back(model(b, pe, pt, 0, (k == 0) ? -1 : 1));
            frames_sent++;
            @(negedge clk);
            chk("burst_accept", 32'(busy), 32'(1));
            n = 0;
            while (busy && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        data_valid = 1'b0;

        send(8'h3C, 1, 0, 0, 1);
        send(8'h96, 1, 1, 2, 0);
        send(8'h5A, 0, 0, 1, 0);
        send(8'hC3, 1, 1, 1, 1);

        // asynchronous reset in the middle of DATA
        wait_idle();
        ser_mode   = 0;
        data_in    = 8'hF0;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        exp_q.push_back(model(8'hF0, 1, 0, 0, -1));
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        abort_flag = 1;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_tx", 32'(tx_out), 32'(1));
        chk("abort_ser_en", 32'(ser_en), 32'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        send(8'h81, 1, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            int m;
            m = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 m, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        chk("frame_count", 32'(frames_done), 32'(frames_sent));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
